// File: rtl/input_pkg.sv
// Shared constants and types for the board input front end.
// Button bit order matches the physical C, U, R, L, D layout.
package input_pkg;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_R = 2;
  localparam int BTN_L = 3;
  localparam int BTN_D = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-FF synchroniser, debounce counter, registered rise/fall strobes.
// Level and strobes update on the (DB_CYCLES+2)th edge after a raw change; no backpressure.
module debounce_channel #(
  parameter int DB_CYCLES = 500000
) (
  input  logic ClkPort,
  input  logic Reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          hit;

  // The counter never passes CNT_LAST: it clears on acceptance or on any
  // cycle where the synchronised input agrees with the accepted level.
  assign hit = (s2 != level) && (cnt == CNT_LAST);

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= hit & ~level;
      fall <= hit & level;
      if (s2 == level) begin
        cnt <= '0;
      end else if (hit) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Debounces all buttons and switches and adds per-button auto-repeat strobes.
// Outputs lag raw pins by DB_CYCLES+2 edges; strobes are single-cycle with no handshake.
module input_conditioner
  import input_pkg::*;
#(
  parameter int NUM_BTN   = 5,
  parameter int NUM_SW    = 8,
  parameter int DB_CYCLES = 500000,
  parameter int RPT_DELAY = 40000000,
  parameter int RPT_RATE  = 10000000
) (
  input  logic               ClkPort,
  input  logic               Reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_SW-1:0]  sw_raw,
  input  logic [NUM_BTN-1:0] rpt_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic [NUM_SW-1:0]  sw_level,
  output logic [NUM_SW-1:0]  sw_change
);

  localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int HW      = $clog2(RPT_MAX + 1);
  localparam logic [HW-1:0] DELAY_C = HW'(RPT_DELAY);
  localparam logic [HW-1:0] RATE_C  = HW'(RPT_RATE);

  logic [NUM_SW-1:0] sw_rise;
  logic [NUM_SW-1:0] sw_fall;

  assign sw_change = sw_rise | sw_fall;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_db (
      .ClkPort (ClkPort),
      .Reset   (Reset),
      .raw     (btn_raw[b]),
      .level   (btn_level[b]),
      .rise    (btn_press[b]),
      .fall    (btn_release[b])
    );

    rpt_state_t    st_q;
    rpt_state_t    st_d;
    logic [HW-1:0] cnt_q;
    logic [HW-1:0] cnt_d;
    logic [HW-1:0] cnt_inc;
    logic          due_d;
    logic          rpt_q;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // cnt_q holds the number of cycles elapsed since the last strobe.
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      due_d = 1'b0;
      case (st_q)
        IDLE: begin
          cnt_d = '0;
          if (btn_press[b]) begin
            if (DELAY_C == 1) begin
              st_d  = REPEAT;
              due_d = 1'b1;
            end else begin
              st_d     = DELAY;
              cnt_d[0] = 1'b1;
            end
          end
        end
        DELAY: begin
          if (!btn_level[b]) begin
            st_d  = IDLE;
            cnt_d = '0;
          end else if (cnt_inc == DELAY_C) begin
            st_d  = REPEAT;
            cnt_d = '0;
            due_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        REPEAT: begin
          if (!btn_level[b]) begin
            st_d  = IDLE;
            cnt_d = '0;
          end else if (cnt_inc == RATE_C) begin
            cnt_d = '0;
            due_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          st_d  = IDLE;
          cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        rpt_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        rpt_q <= due_d & rpt_en[b];
      end
    end

    // A repeat landing in the cycle the level drops is masked by the level itself.
    assign btn_repeat[b] = btn_press[b] | (rpt_q & btn_level[b]);
  end

  for (genvar s = 0; s < NUM_SW; s++) begin : g_sw
    debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_db (
      .ClkPort (ClkPort),
      .Reset   (Reset),
      .raw     (sw_raw[s]),
      .level   (sw_level[s]),
      .rise    (sw_rise[s]),
      .fall    (sw_fall[s])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short debounce and repeat timings.
module tb_input_conditioner;

  logic       ClkPort;
  logic       Reset;
  logic [4:0] btn_raw;
  logic [7:0] sw_raw;
  logic [4:0] rpt_en;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [4:0] btn_release;
  logic [4:0] btn_repeat;
  logic [7:0] sw_level;
  logic [7:0] sw_change;

  int n_total = 0;
  int n_bad   = 0;

  input_conditioner #(
    .NUM_BTN   (5),
    .NUM_SW    (8),
    .DB_CYCLES (4),
    .RPT_DELAY (10),
    .RPT_RATE  (3)
  ) dut (
    .ClkPort     (ClkPort),
    .Reset       (Reset),
    .btn_raw     (btn_raw),
    .sw_raw      (sw_raw),
    .rpt_en      (rpt_en),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat),
    .sw_level    (sw_level),
    .sw_change   (sw_change)
  );

  initial ClkPort = 1'b0;
  always #5 ClkPort = ~ClkPort;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge ClkPort);
      #1;
    end
  endtask

  // Holds btn_raw[2] from press until 13 cycles after the press strobe,
  // recording repeat/release/press strobes over a 25-cycle window.
  task automatic hold_btn2(output logic [31:0] rep, output logic [31:0] rel,
                           output logic [31:0] prs);
    rep = '0;
    rel = '0;
    prs = '0;
    btn_raw[2] = 1'b1;
    tick(6);
    for (int i = 0; i < 25; i++) begin
      rep[i] = btn_repeat[2];
      rel[i] = btn_release[2];
      prs[i] = btn_press[2];
      if (i == 13) btn_raw[2] = 1'b0;
      tick(1);
    end
  endtask

  logic [31:0] rep;
  logic [31:0] rel;
  logic [31:0] prs;
  logic [4:0]  acc_btn;

  initial begin
    Reset   = 1'b1;
    btn_raw = '0;
    sw_raw  = '0;
    rpt_en  = '0;
    tick(2);
    chk("rst_btn_level", 32'(btn_level), 32'h0);
    chk("rst_btn_strobes", 32'({btn_press, btn_release, btn_repeat}), 32'h0);
    chk("rst_sw", 32'({sw_level, sw_change}), 32'h0);
    Reset = 1'b0;
    tick(2);

    // clean press on button 1
    btn_raw = 5'b00010;
    tick(5);
    chk("press_early_level", 32'(btn_level), 32'h0);
    tick(1);
    chk("press_level", 32'(btn_level), 32'h02);
    chk("press_strobe", 32'(btn_press), 32'h02);
    chk("press_repeat", 32'(btn_repeat), 32'h02);
    tick(1);
    chk("press_one_cycle", 32'(btn_press), 32'h0);
    chk("press_level_hold", 32'(btn_level), 32'h02);
    btn_raw = 5'b00000;
    tick(6);
    chk("release_strobe", 32'(btn_release), 32'h02);
    chk("release_level", 32'(btn_level), 32'h0);
    tick(1);
    chk("release_one_cycle", 32'(btn_release), 32'h0);

    // three-cycle glitch on button 0
    acc_btn = '0;
    btn_raw[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) btn_raw[0] = 1'b0;
      tick(1);
      acc_btn = acc_btn | btn_level | btn_press | btn_release;
    end
    chk("glitch_rejected", 32'(acc_btn), 32'h0);

    // auto-repeat enabled; release lands on a due repeat at P+19
    rpt_en = 5'b00100;
    hold_btn2(rep, rel, prs);
    chk("rpt_on_repeat", rep, 32'h0001_2401);
    chk("rpt_on_release", rel, 32'h0008_0000);
    chk("rpt_on_press", prs, 32'h0000_0001);
    tick(3);

    // auto-repeat disabled
    rpt_en = 5'b00000;
    hold_btn2(rep, rel, prs);
    chk("rpt_off_repeat", rep, 32'h0000_0001);
    chk("rpt_off_release", rel, 32'h0008_0000);
    tick(3);

    // switches 0x00 -> 0xA5
    sw_raw = 8'hA5;
    tick(5);
    chk("sw_early_level", 32'(sw_level), 32'h0);
    tick(1);
    chk("sw_level", 32'(sw_level), 32'hA5);
    chk("sw_change", 32'(sw_change), 32'hA5);
    tick(1);
    chk("sw_change_one_cycle", 32'(sw_change), 32'h0);
    chk("sw_level_hold", 32'(sw_level), 32'hA5);

    // reset during the repeat delay with switches at 0xA5
    rpt_en  = 5'b00100;
    btn_raw = 5'b00100;
    tick(6);
    chk("pre_rst_press", 32'(btn_press), 32'h04);
    tick(3);
    Reset = 1'b1;
    #1;
    chk("mid_rst_btn", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'h0);
    chk("mid_rst_sw", 32'({sw_level, sw_change}), 32'h0);
    tick(1);
    Reset = 1'b0;
    tick(5);
    chk("post_rst_early", 32'({btn_level, sw_level}), 32'h0);
    tick(1);
    chk("post_rst_btn_level", 32'(btn_level), 32'h04);
    chk("post_rst_press", 32'(btn_press), 32'h04);
    chk("post_rst_sw_level", 32'(sw_level), 32'hA5);
    chk("post_rst_sw_change", 32'(sw_change), 32'hA5);
    tick(10);
    chk("post_rst_first_repeat", 32'(btn_repeat), 32'h04);

    btn_raw = '0;
    sw_raw  = '0;
    tick(8);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised front end for all board buttons and slide switches in the maze game: it synchronises every raw input, debounces it per channel and produces clean levels plus single-cycle press, release, change and auto-repeat strobes. It sits between the board pins and the game logic, which only ever consumes `btn_press`/`btn_repeat` strobes and `sw_level`, never raw pins. Auto-repeat makes held direction buttons step the player at a fixed rate.

## Interface
- `NUM_BTN`, 5, number of push-button channels (bit index order C, U, R, L, D).
- `NUM_SW`, 8, number of slide-switch channels.
- `DB_CYCLES`, 500000, consecutive stable `ClkPort` cycles needed to accept a new level (5 ms at 100 MHz); must be ≥2.
- `RPT_DELAY`, 40000000, cycles from press strobe to first repeat strobe; must be ≥1.
- `RPT_RATE`, 10000000, cycles between subsequent repeat strobes; must be ≥1.
- `ClkPort` in 1: system clock; all logic is on its rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `btn_raw` in NUM_BTN: raw, asynchronous, active-high buttons.
- `sw_raw` in NUM_SW: raw, asynchronous switches.
- `rpt_en` in NUM_BTN: per-button auto-repeat enable, synchronous to `ClkPort`.
- `btn_level` out NUM_BTN: debounced button level.
- `btn_press` out NUM_BTN: 1-cycle strobe on debounced 0→1.
- `btn_release` out NUM_BTN: 1-cycle strobe on debounced 1→0.
- `btn_repeat` out NUM_BTN: press strobe OR auto-repeat strobes (repeats only when `rpt_en` bit is set).
- `sw_level` out NUM_SW: debounced switch level.
- `sw_change` out NUM_SW: 1-cycle strobe on any debounced switch transition.

## Operation
- Every channel: 2-FF synchroniser (`s1`, `s2`), then a debounce counter of width $clog2(DB_CYCLES).
- The debounce counter clears on any cycle where `s2 == stable`. It increments while `s2 != stable`. On the edge where the count equals DB_CYCLES-1 and `s2 != stable` still holds, `stable` toggles and the counter clears.
- A glitch shorter than DB_CYCLES synchronised cycles never changes `stable`.
- Strobes are registered and assert in the same cycle that `btn_level`/`sw_level` changes.
- Per-button repeat FSM:
  - IDLE: leave on the press strobe to DELAY, hold counter = 0.
  - DELAY: the counter counts cycles. When it reaches RPT_DELAY, pulse `btn_repeat` (if `rpt_en`), go to REPEAT and clear the counter.
  - REPEAT: pulse every RPT_RATE cycles (if `rpt_en`).
  - Any state goes to IDLE on `btn_level` falling. A repeat strobe due in the release cycle is suppressed.
- `rpt_en` is sampled every cycle. Deasserting it mid-hold suppresses strobes but does not reset the FSM timing.
- Width rules: hold counter width = $clog2(max(RPT_DELAY, RPT_RATE)+1). Counters saturate, they do not wrap.

## Timing
- Reset forces all synchronisers, `stable` bits, counters, FSMs (IDLE) and all outputs to 0.
- A switch that is on at reset therefore produces one `sw_change` after release from reset.
- Reset mid-debounce discards the partial count.
- Latency: the level changes on the (DB_CYCLES+2)th rising edge after a raw change, counting the capturing edge.
- Simultaneous press on several channels: channels are fully independent, so all strobes fire in the same cycle.
- No handshake. Strobes are exactly 1 cycle, and consumers must sample every cycle.

## Structure
- Package `input_pkg`:
  - button index constants BTN_C=0, BTN_U=1, BTN_R=2, BTN_L=3, BTN_D=4;
  - repeat FSM state enum {IDLE, DELAY, REPEAT}.
- Sub-module `debounce_channel` (synchroniser + debounce counter + edge strobes, parameter DB_CYCLES) is instantiated NUM_BTN+NUM_SW times via generate.
- The repeat FSM lives in the top of this block, per button.

## Test plan
Bench parameters: DB_CYCLES=4, RPT_DELAY=10, RPT_RATE=3.
- **Clean press:** `btn_raw[1]` 0→1 and held.
  - `btn_level[1]`=1 and `btn_press[1]`=1 six edges later.
  - `btn_press` is high for exactly one cycle.
- **Glitch rejection:** `btn_raw[0]` high for 3 cycles, then low.
  - `btn_level`, `btn_press` and `btn_release` stay 0.
- **Auto-repeat:** `rpt_en[2]`=1, hold `btn_raw[2]` with press strobe at cycle P.
  - `btn_repeat[2]` pulses at P, P+10, P+13, P+16.
  - On release: one `btn_release` strobe and no further `btn_repeat`.
- **Repeat disabled:** same stimulus with `rpt_en[2]`=0.
  - `btn_repeat[2]` pulses only at P.
- **Switch change:** `sw_raw` 0x00→0xA5.
  - `sw_level`=0xA5 six edges later.
  - `sw_change`=0xA5 for one cycle.
- **Reset mid-operation:** assert `Reset` for 1 cycle during DELAY with `sw_level` at 0xA5.
  - All outputs are 0 immediately.
  - With raw inputs held, level returns six edges after `Reset` deasserts, with a fresh `btn_press`/`sw_change`.
